// File: rtl/count_uart_reader_if.sv
// -----------------------------------------------------------------------------
// count_uart_reader_if
//   Link between the photon counter and its reader.
//
//   Signals:
//     cnt_in   [31:0]  live count, driven by the counter
//     cnt_clr          one-cycle active-high clear, driven by the reader
//
//   Modports:
//     master  reader side (samples cnt_in, drives cnt_clr)
//     slave   counter side (drives cnt_in, samples cnt_clr)
// -----------------------------------------------------------------------------
interface count_uart_reader_if;
    logic [31:0] cnt_in;
    logic        cnt_clr;

    modport master (input  cnt_in, output cnt_clr);
    modport slave  (output cnt_in, input  cnt_clr);
endinterface : count_uart_reader_if

// File: rtl/count_uart_reader.sv
// -----------------------------------------------------------------------------
// count_uart_reader
//   Opens a fixed-length counting gate, snapshots the photon counter when the
//   gate closes, clears the counter for one cycle and sends the snapshot to the
//   host as a framed 8N1 UART byte stream:
//     SYNC_BYTE, cnt[31:24], cnt[23:16], cnt[15:8], cnt[7:0], CHK
//   CHK is the XOR of the count bytes. Bytes go out back-to-back.
//
//   Optional build macro SEQ_NUM_EN: adds an 8-bit frame sequence number
//   after SYNC_BYTE (7-byte frame); it is included in CHK and advances on
//   every frame start. Dropped snapshots do not consume a number.
//
//   Ports:
//     clk50Mhz  in   system clock, rising edge
//     rst       in   asynchronous active-low reset
//     cnt_bus   if   master side of count_uart_reader_if (cnt_in / cnt_clr)
//     uart_tx   out  serial line, idles high
//     busy      out  high while a frame is being shifted out
//     overrun   out  sticky: a waiting snapshot was overwritten before it
//                    started transmission
// -----------------------------------------------------------------------------
module count_uart_reader #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned GATE_CYCLES = 5_000_000,   // must be >= 2
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic                clk50Mhz,
    input  logic                rst,
    count_uart_reader_if.master cnt_bus,
    output logic                uart_tx,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned BAUD_DIV  = CLK_HZ / BAUD;
    localparam int unsigned TW        = $clog2(GATE_CYCLES);
    localparam int unsigned BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
`ifdef SEQ_NUM_EN
    localparam int unsigned N_BYTES = 7;
`else
    localparam int unsigned N_BYTES = 6;
`endif
    localparam logic [2:0] LAST_IDX = 3'(N_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

    logic [TW-1:0] r_timer;
    logic [31:0]   r_shadow;
    logic          r_pending;
    logic          r_overrun;
    tx_state_e     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [2:0]    r_idx;
    logic [31:0]   r_frame;
    logic          r_busy;
    logic          r_tx;
`ifdef SEQ_NUM_EN
    logic [7:0]    r_seq;
    logic [7:0]    r_frame_seq;
`endif

    logic          w_gate_end;
    logic          w_take;
    logic          w_baud_done;
    logic [7:0]    w_chk;
    logic [7:0]    w_byte;
    tx_state_e     w_next_state;
    logic [BW-1:0] w_next_baud;
    logic [2:0]    w_next_bit;
    logic [2:0]    w_next_idx;
    logic          w_next_tx;

    assign w_gate_end  = (r_timer == GATE_LAST);
    // A waiting snapshot is claimed by the FSM only from IDLE.
    assign w_take      = (r_state == S_IDLE) && r_pending;
    assign w_baud_done = (r_baud == BAUD_LAST);

    assign cnt_bus.cnt_clr = w_gate_end;
    assign uart_tx         = r_tx;
    assign busy            = r_busy;
    assign overrun         = r_overrun;

    // ------------------------------------------------------------ gate timer
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design updates from the same pre-edge values.
    always_ff @(posedge clk50Mhz or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (w_gate_end) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // ------------------------------------------------- snapshot and overrun
    // A new snapshot landing on a still-waiting one is an overrun, unless the
    // FSM is claiming the waiting one in this very cycle.
    // NOTE: the datapath registers are reset as well; they are few and it
    // keeps an abandoned or early frame free of X.
    always_ff @(posedge clk50Mhz or negedge rst) begin
        if (!rst) begin
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_gate_end) begin
            r_shadow  <= cnt_bus.cnt_in;
            r_pending <= 1'b1;
            if (r_pending && !w_take) begin
                r_overrun <= 1'b1;
            end
        end else if (w_take) begin
            r_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------ frame contents
`ifdef SEQ_NUM_EN
    assign w_chk = r_frame[31:24] ^ r_frame[23:16] ^ r_frame[15:8] ^ r_frame[7:0]
                 ^ r_frame_seq;
    always_comb begin
        unique case (r_idx)
            3'd0:    w_byte = SYNC_BYTE;
            3'd1:    w_byte = r_frame_seq;
            3'd2:    w_byte = r_frame[31:24];
            3'd3:    w_byte = r_frame[23:16];
            3'd4:    w_byte = r_frame[15:8];
            3'd5:    w_byte = r_frame[7:0];
            default: w_byte = w_chk;
        endcase
    end
`else
    assign w_chk = r_frame[31:24] ^ r_frame[23:16] ^ r_frame[15:8] ^ r_frame[7:0];
    always_comb begin
        unique case (r_idx)
            3'd0:    w_byte = SYNC_BYTE;
            3'd1:    w_byte = r_frame[31:24];
            3'd2:    w_byte = r_frame[23:16];
            3'd3:    w_byte = r_frame[15:8];
            3'd4:    w_byte = r_frame[7:0];
            default: w_byte = w_chk;
        endcase
    end
`endif

    // ------------------------------------------------ TX FSM, next state
    // The line value is computed for the next state and registered, so
    // uart_tx comes straight from a flop and never glitches.
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_baud  = r_baud + 1'b1;
        w_next_bit   = r_bit;
        w_next_idx   = r_idx;
        w_next_tx    = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                w_next_baud = '0;
                if (r_pending) begin
                    w_next_state = S_START;
                    w_next_idx   = '0;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_next_state = S_DATA;
                    w_next_baud  = '0;
                    w_next_bit   = '0;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_next_baud = '0;
                    if (r_bit == 3'd7) begin
                        w_next_state = S_STOP;
                    end else begin
                        w_next_bit = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_next_baud = '0;
                    if (r_idx == LAST_IDX) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_idx   = r_idx + 3'd1;
                        w_next_state = S_START;
                    end
                end
            end
        endcase

        unique case (w_next_state)
            S_START: w_next_tx = 1'b0;
            S_DATA:  w_next_tx = w_byte[w_next_bit];
            default: w_next_tx = 1'b1;
        endcase
    end

    // ------------------------------------------------ TX FSM, registers
    always_ff @(posedge clk50Mhz or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_baud  <= w_next_baud;
            r_bit   <= w_next_bit;
            r_idx   <= w_next_idx;
            r_busy  <= (w_next_state != S_IDLE);
            r_tx    <= w_next_tx;
        end
    end

    // The in-flight frame works from its own copy, so later snapshots only
    // touch r_shadow.
    always_ff @(posedge clk50Mhz or negedge rst) begin
        if (!rst) begin
            r_frame <= '0;
        end else if (w_take) begin
            r_frame <= r_shadow;
        end
    end

`ifdef SEQ_NUM_EN
    always_ff @(posedge clk50Mhz or negedge rst) begin
        if (!rst) begin
            r_seq       <= '0;
            r_frame_seq <= '0;
        end else if (w_take) begin
            r_frame_seq <= r_seq;
            r_seq       <= r_seq + 8'd1;
        end
    end
`endif

endmodule : count_uart_reader
